// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared types and constants for the DDS command sequencer.
//   dds_state_t : sequencer FSM states
//   dds_cmd_t   : one queued command {rwn, data[31:0]} (33 bits)
//   DDS_RWN_*   : encoding of the controller R/Wn level
//   DDS_DEFAULT_TIMEOUT / DDS_DEFAULT_GAP : default timing parameters
// -----------------------------------------------------------------------------
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_GAP
  } dds_state_t;

  typedef struct packed {
    logic        rwn;
    logic [31:0] data;
  } dds_cmd_t;

  localparam logic DDS_RWN_READ  = 1'b1;
  localparam logic DDS_RWN_WRITE = 1'b0;

  localparam int DDS_DEFAULT_TIMEOUT = 63;
  localparam int DDS_DEFAULT_GAP     = 2;

endpackage

// File: rtl/dds_cmd_fifo.sv
// -----------------------------------------------------------------------------
// dds_cmd_fifo
// Synchronous command FIFO, DEPTH entries of dds_cmd_t.
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : empties the FIFO on the next edge; wins over push and pop
//   push       : write push_data (ignored when full)
//   pop        : advance past head (ignored when empty)
//   head       : entry at the read pointer (valid while !empty)
//   full/empty : status flags derived from level
//   level      : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module dds_cmd_fifo
  import dds_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         push,
  input  dds_cmd_t                     push_data,
  input  logic                         pop,
  output dds_cmd_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  dds_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH on their own.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents are only observed after a
  // push has written them, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dds_cmd_seq.sv
// -----------------------------------------------------------------------------
// dds_cmd_seq
// Queues DDS register read/write commands and plays them one at a time into
// the DDS parallel-port controller over its Start/Busy handshake.
//   clk, rstn            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command push handshake (ready = FIFO not full)
//   cmd_rwn, cmd_data    : command type (1=read) and address/data word
//   flush                : drop all queued commands (in-flight one completes)
//   fifo_level           : entries queued
//   idle                 : FIFO empty and sequencer in IDLE
//   rd_valid, rd_data    : one-cycle read-back pulse and captured word
//   err_timeout, err_clr : sticky "controller never went busy" flag and clear
//   dds_start, dds_busy  : transaction request / controller busy
//   dds_dataout, dds_wr  : word and R/Wn level presented to the controller
//   dds_datain           : controller read-back word
// -----------------------------------------------------------------------------
module dds_cmd_seq
  import dds_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = DDS_DEFAULT_TIMEOUT,
  parameter int GAP     = DDS_DEFAULT_GAP
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rwn,
  input  logic [31:0]                 cmd_data,
  input  logic                        flush,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output logic                        idle,
  output logic                        rd_valid,
  output logic [31:0]                 rd_data,
  output logic                        err_timeout,
  input  logic                        err_clr,
  output logic                        dds_start,
  input  logic                        dds_busy,
  output logic [31:0]                 dds_dataout,
  output logic                        dds_wr,
  input  logic [31:0]                 dds_datain
);

  // One counter serves as the LAUNCH timeout timer and the GAP timer.
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  dds_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  dds_cmd_t       push_cmd;
  dds_cmd_t       head;
  dds_cmd_t       cur_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           abort;
  logic           rd_done;

  assign push_cmd = '{rwn: cmd_rwn, data: cmd_data};

  dds_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Ready depends on the full flag alone: a pop in the same cycle does not
  // open a slot for a push.
  assign cmd_ready   = !fifo_full;
  assign idle        = fifo_empty && (state_q == ST_IDLE);
  assign dds_start   = (state_q == ST_LAUNCH);
  // The captured command is only reloaded on the next pop, so the word and
  // R/Wn level stay put for the whole controller frame.
  assign dds_dataout = cur_q.data;
  assign dds_wr      = cur_q.rwn;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pop     = 1'b0;
    abort   = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !dds_busy) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (dds_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!dds_busy) begin
          rd_done = (cur_q.rwn == DDS_RWN_READ);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '{rwn: DDS_RWN_READ, data: 32'h0};
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_valid <= rd_done;
      if (pop)     cur_q   <= head;
      if (rd_done) rd_data <= dds_datain;
      // A new abort wins over a clear arriving in the same cycle.
      if (abort)        err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_dds_cmd_seq
// Directed bench for dds_cmd_seq. Stimulus pushes the expected controller
// transactions and read-back words into queues; a monitor on the falling edge
// pops and compares whenever the DUT raises dds_start or rd_valid. A simple
// controller model raises busy 3 cycles after start and holds it 25 cycles;
// force_hi / force_lo override it to hold busy stuck high or tied low.
// -----------------------------------------------------------------------------
module tb_dds_cmd_seq;
  import dds_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 63;
  localparam int GAP     = 2;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rwn;
  logic [31:0] cmd_data;
  logic        flush;
  logic [4:0]  fifo_level;
  logic        idle;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err_timeout;
  logic        err_clr;
  logic        dds_start;
  logic        dds_busy;
  logic [31:0] dds_dataout;
  logic        dds_wr;
  logic [31:0] dds_datain;

  logic        force_hi;
  logic        force_lo;
  logic        model_busy;

  assign dds_busy = force_hi ? 1'b1 : (force_lo ? 1'b0 : model_busy);

  dds_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rwn     (cmd_rwn),
    .cmd_data    (cmd_data),
    .flush       (flush),
    .fifo_level  (fifo_level),
    .idle        (idle),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .dds_start   (dds_start),
    .dds_busy    (dds_busy),
    .dds_dataout (dds_dataout),
    .dds_wr      (dds_wr),
    .dds_datain  (dds_datain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  dds_cmd_t    exp_txn [$];
  logic [31:0] exp_rd  [$];
  int          high_len = 0;
  int          low_len = 0;
  int          last_high_len = 0;
  bit          seen_fall = 1'b0;
  logic        prev_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_rd_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Controller model: busy rises 3 cycles after start, held 25 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dds_start) begin
        repeat (2) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (25) @(posedge clk);
        #1 model_busy = 1'b0;
        while (dds_start) begin
          @(posedge clk); #1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    dds_cmd_t e;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (dds_start && !prev_start) begin
          if (exp_txn.size() == 0) begin
            fail_event("txn", $sformatf("unexpected start, dataout=0x%08h", dds_dataout));
          end else begin
            e = exp_txn.pop_front();
            check("txn_dataout", dds_dataout, e.data);
            check("txn_wr", {31'b0, dds_wr}, {31'b0, e.rwn});
          end
          if (seen_fall) begin
            n_vec++;
            if (low_len < GAP) begin
              n_err++;
              $display("FAIL start_gap: got %0d low cycles, expected >= %0d", low_len, GAP);
            end
          end
        end
        if (prev_start && prev_busy)
          check("start_drop_after_busy", {31'b0, dds_start}, 32'h0);
        if (rd_valid) begin
          check("rd_valid_one_cycle", {31'b0, prev_rd_valid}, 32'h0);
          if (exp_rd.size() == 0) begin
            fail_event("rd", $sformatf("unexpected rd_valid, rd_data=0x%08h", rd_data));
          end else begin
            er = exp_rd.pop_front();
            check("rd_data", rd_data, er);
          end
        end
      end
      if (dds_start) begin
        if (!prev_start) high_len = 0;
        high_len++;
      end else begin
        if (prev_start) begin
          last_high_len = high_len;
          seen_fall     = 1'b1;
          low_len       = 0;
        end
        low_len++;
      end
      prev_start    = dds_start;
      prev_busy     = dds_busy;
      prev_rd_valid = rd_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic rwn, input logic [31:0] data, input bit predict);
    cmd_valid = 1'b1;
    cmd_rwn   = rwn;
    cmd_data  = data;
    if (predict) exp_txn.push_back('{rwn: rwn, data: data});
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (idle && !dds_busy) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: idle not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_rise(input string name, input int budget);
    bit   done = 1'b0;
    logic last = dds_start;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (dds_start && !last) begin
        done = 1'b1;
        break;
      end
      last = dds_start;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: no start rise within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_busy(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (dds_busy) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: busy not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},   {31'b0, cmd_ready},   32'h1);
    check({tag, "_fifo_level"},  {27'b0, fifo_level},  32'h0);
    check({tag, "_idle"},        {31'b0, idle},        32'h1);
    check({tag, "_rd_valid"},    {31'b0, rd_valid},    32'h0);
    check({tag, "_rd_data"},     rd_data,              32'h0);
    check({tag, "_err_timeout"}, {31'b0, err_timeout}, 32'h0);
    check({tag, "_dds_start"},   {31'b0, dds_start},   32'h0);
    check({tag, "_dds_dataout"}, dds_dataout,          32'h0);
    check({tag, "_dds_wr"},      {31'b0, dds_wr},      32'h1);
  endtask

  initial begin
    rstn       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_rwn    = 1'b0;
    cmd_data   = '0;
    flush      = 1'b0;
    err_clr    = 1'b0;
    dds_datain = '0;
    force_hi   = 1'b0;
    force_lo   = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");
    rstn = 1'b1;
    @(posedge clk); #2;

    // 1: single write
    push(DDS_RWN_WRITE, 32'h0112_3456, 1'b1);
    wait_idle("t1_idle_wait", 200);
    check("t1_idle", {31'b0, idle}, 32'h1);
    check("t1_wr_held", {31'b0, dds_wr}, 32'h0);

    // 2: single read
    dds_datain = 32'hA5A5_5A5A;
    exp_rd.push_back(32'hA5A5_5A5A);
    push(DDS_RWN_READ, 32'h8100_0000, 1'b1);
    wait_idle("t2_idle_wait", 200);
    check("t2_rd_data_held", rd_data, 32'hA5A5_5A5A);
    check("t2_rd_valid_low", {31'b0, rd_valid}, 32'h0);

    // 3: burst of three writes; busy held high while queueing
    force_hi = 1'b1;
    push(DDS_RWN_WRITE, 32'h11, 1'b1);
    push(DDS_RWN_WRITE, 32'h22, 1'b1);
    push(DDS_RWN_WRITE, 32'h33, 1'b1);
    check("t3_level_3", {27'b0, fifo_level}, 32'd3);
    check("t3_not_idle", {31'b0, idle}, 32'h0);
    force_hi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_rise("t3_rise", 200);
      check("t3_level_at_start", {27'b0, fifo_level}, 32'(2 - k));
    end
    wait_idle("t3_idle_wait", 300);

    // 4: fill the FIFO behind a stuck transaction
    push(DDS_RWN_WRITE, 32'h4000_0000, 1'b1);
    wait_rise("t4_first_rise", 50);
    force_hi = 1'b1;
    for (int k = 1; k <= 16; k++) push(DDS_RWN_WRITE, 32'h4000_0000 + 32'(k), 1'b1);
    check("t4_level_full", {27'b0, fifo_level}, 32'd16);
    check("t4_cmd_ready_low", {31'b0, cmd_ready}, 32'h0);
    push(DDS_RWN_WRITE, 32'h4000_0011, 1'b0);
    check("t4_17th_refused", {27'b0, fifo_level}, 32'd16);
    force_hi = 1'b0;
    wait_idle("t4_drain_wait", 2000);
    check("t4_level_empty", {27'b0, fifo_level}, 32'd0);

    // 5: timeout with busy tied low
    force_lo = 1'b1;
    push(DDS_RWN_WRITE, 32'h5000_0001, 1'b1);
    wait_idle("t5_idle_wait", 200);
    check("t5_start_len", 32'(last_high_len), 32'(TIMEOUT));
    check("t5_err_set", {31'b0, err_timeout}, 32'h1);
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    check("t5_err_cleared", {31'b0, err_timeout}, 32'h0);
    push(DDS_RWN_WRITE, 32'h5000_0002, 1'b1);
    wait_rise("t5_second_rise", 20);
    repeat (TIMEOUT - 1) @(posedge clk);
    #2;
    check("t5_start_still_high", {31'b0, dds_start}, 32'h1);
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    check("t5_set_beats_clr", {31'b0, err_timeout}, 32'h1);
    check("t5_start_dropped", {31'b0, dds_start}, 32'h0);
    force_lo = 1'b0;
    wait_idle("t5_idle_wait2", 200);
    err_clr = 1'b1;
    @(posedge clk); #2;
    err_clr = 1'b0;
    check("t5_err_cleared2", {31'b0, err_timeout}, 32'h0);

    // 6a: flush during the first read's WAIT_DONE
    dds_datain = 32'h6666_0001;
    exp_rd.push_back(32'h6666_0001);
    push(DDS_RWN_READ, 32'h8100_0001, 1'b1);
    push(DDS_RWN_READ, 32'h8100_0002, 1'b0);
    push(DDS_RWN_READ, 32'h8100_0003, 1'b0);
    push(DDS_RWN_READ, 32'h8100_0004, 1'b0);
    wait_busy("t6_busy_wait", 50);
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    check("t6_level_flushed", {27'b0, fifo_level}, 32'd0);
    wait_idle("t6_idle_wait", 200);
    repeat (100) @(posedge clk);
    #2;
    check("t6_idle_after_flush", {31'b0, idle}, 32'h1);

    // 6b: reset in the middle of WAIT_DONE
    push(DDS_RWN_READ, 32'h8200_0001, 1'b1);
    push(DDS_RWN_READ, 32'h8200_0002, 1'b0);
    push(DDS_RWN_READ, 32'h8200_0003, 1'b0);
    push(DDS_RWN_READ, 32'h8200_0004, 1'b0);
    wait_busy("t6b_busy_wait", 50);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    wait_idle("t6b_idle_wait", 200);
    repeat (50) @(posedge clk);
    #2;
    check("t6b_level", {27'b0, fifo_level}, 32'd0);
    check("t6b_start_low", {31'b0, dds_start}, 32'h0);

    check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
